// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg (package)
//  Description : Shared types and constants for the UART TX arbiter and any
//                other shared-resource arbiter built on uart_rr_pick.
//                  arb_state_t  - arbiter FSM state encoding
//                  MAX_CLIENTS  - largest supported requester count
//                  id_width()   - index width for a given client count
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int MAX_CLIENTS = 8;

    // Width of a client index. Never below one bit so a two-client
    // arbiter still has a usable index register.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Client-side and UART-side byte handshake bundle for the
//                UART TX arbiter.
//                  req_valid/req_data/req_last/req_ready : N client byte ports
//                                                          (client i data at
//                                                          [8i+7:8i])
//                  tx_valid/tx_data/tx_ready             : byte port to UART TX
//                  grant_valid/grant_id/tmo_pulse        : ownership status
//                modport slave  : the arbiter
//                modport master : the clients plus the UART TX sink
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int ID_W      = id_width(N_CLIENTS)
);

    logic [N_CLIENTS-1:0]   req_valid;
    logic [N_CLIENTS*8-1:0] req_data;
    logic [N_CLIENTS-1:0]   req_last;
    logic [N_CLIENTS-1:0]   req_ready;

    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic                   tx_ready;

    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;
    logic                   tmo_pulse;

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant_valid, grant_id, tmo_pulse
    );

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_valid, grant_id, tmo_pulse
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational round-robin picker. Finds the first set bit of
//                the request vector searching upward from a pointer, wrapping
//                from N-1 back to 0. Never returns an index >= N, including
//                for non-power-of-two N.
//  Ports       : i_req   [N-1:0]     request vector
//                i_ptr   [IDX_W-1:0] search start (must be < N)
//                o_found             at least one request set
//                o_index [IDX_W-1:0] selected request index
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic                  o_found,
    output logic [IDX_W-1:0]      o_index
);

    // One spare bit: ptr + offset can reach 2N-2.
    localparam int c_SUM_W = IDX_W + 1;

    logic [N-1:0]       w_rot;
    logic [c_SUM_W-1:0] w_pos;
    logic [c_SUM_W-1:0] w_sum;

    always_comb begin
        // Rotate so that the pointer position lands on bit 0; the doubled
        // vector supplies the wrapped-around bits.
        w_rot   = N'({i_req, i_req} >> i_ptr);

        // Lowest set bit of the rotated vector is the closest request at or
        // above the pointer. Scanning downward lets the lowest hit win.
        o_found = 1'b0;
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_pos   = c_SUM_W'(k);
            end
        end

        // Undo the rotation with a modulo-N add.
        w_sum   = {1'b0, i_ptr} + w_pos;
        if (w_sum >= c_SUM_W'(N)) begin
            o_index = IDX_W'(w_sum - c_SUM_W'(N));
        end else begin
            o_index = IDX_W'(w_sum);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter among N_CLIENTS byte-stream
//                requesters. Round-robin grant per packet; the grant is held
//                until the owner's last byte, MAX_BURST bytes, or IDLE_TMO
//                cycles with the owner's valid low.
//  Parameters  : N_CLIENTS (2..8), MAX_BURST (1..255), IDLE_TMO (1..4095)
//  Ports       : clk    clock
//                reset  asynchronous, active-high
//                bus    uart_tx_arbiter_if.slave (client ports, UART TX byte
//                       port, grant_valid/grant_id/tmo_pulse status)
//  Config      : UART_ARB_PRIO_EN - when defined, client 0 wins every
//                arbitration it takes part in and its release does not
//                advance the round-robin pointer. Undefined: pure
//                round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TMO  = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uart_tx_arbiter_if.slave   bus
);

    localparam int         c_ID_W       = id_width(N_CLIENTS);
    localparam logic [7:0]  c_BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [11:0] c_TMO_LAST   = 12'(IDLE_TMO - 1);
    localparam logic [c_ID_W-1:0] c_ID_MAX = c_ID_W'(N_CLIENTS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t          r_state;
    logic                r_grant_valid;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [7:0]          r_burst_cnt;
    logic [11:0]         r_tmo_cnt;
    logic                r_tmo_pulse;

    arb_state_t          w_state_nxt;
    logic                w_grant_valid_nxt;
    logic [c_ID_W-1:0]   w_grant_id_nxt;
    logic [c_ID_W-1:0]   w_rr_ptr_nxt;
    logic [7:0]          w_burst_cnt_nxt;
    logic [11:0]         w_tmo_cnt_nxt;
    logic                w_tmo_pulse_nxt;

    // ------------------------------------------------------------------
    // Owner-side mux and arbitration helpers
    // ------------------------------------------------------------------
    logic                w_own_valid;
    logic                w_own_last;
    logic [7:0]          w_own_data;
    logic                w_xfer;
    logic                w_release;

    logic                w_rr_found;
    logic [c_ID_W-1:0]   w_rr_index;
    logic [c_ID_W-1:0]   w_pick_id;
    logic [c_ID_W-1:0]   w_ptr_inc;
    logic [c_ID_W-1:0]   w_rr_after;

    assign w_own_valid = bus.req_valid[r_grant_id];
    assign w_own_last  = bus.req_last[r_grant_id];
    assign w_own_data  = bus.req_data[8*r_grant_id +: 8];
    assign w_xfer      = w_own_valid & bus.tx_ready;

    uart_rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (c_ID_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_rr_found),
        .o_index (w_rr_index)
    );

    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-two N.
    assign w_ptr_inc = (r_grant_id == c_ID_MAX) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_pick_id  = w_rr_index;
        w_rr_after = w_ptr_inc;
`ifdef UART_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            w_pick_id = '0;
        end
        // Client 0 jumping the queue must not disturb the rotation the
        // other clients are waiting on.
        if (r_grant_id == '0) begin
            w_rr_after = r_rr_ptr;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            r_tmo_cnt     <= '0;
            r_tmo_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_burst_cnt   <= w_burst_cnt_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_tmo_pulse   <= w_tmo_pulse_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_burst_cnt_nxt   = r_burst_cnt;
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_tmo_pulse_nxt   = 1'b0;
        w_release         = 1'b0;

        bus.tx_valid      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.req_ready     = '0;

        case (r_state)
            ARB_IDLE: begin
                // Grant is registered here; the winner's first byte can move
                // on the following cycle at the earliest.
                if (w_rr_found) begin
                    w_state_nxt       = ARB_OWN;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_id_nxt    = w_pick_id;
                    w_burst_cnt_nxt   = '0;
                    w_tmo_cnt_nxt     = '0;
                end
            end

            ARB_OWN: begin
                bus.tx_valid  = w_own_valid;
                bus.tx_data   = w_own_data;
                bus.req_ready = bus.tx_ready
                              ? ({{(N_CLIENTS-1){1'b0}}, 1'b1} << r_grant_id)
                              : '0;

                if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + 8'd1;
                    w_tmo_cnt_nxt   = '0;
                    // last and burst cap on the same byte collapse into one
                    // release, so the pointer only moves once.
                    if (w_own_last || (r_burst_cnt == c_BURST_LAST)) begin
                        w_release = 1'b1;
                    end
                end else if (!w_own_valid) begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 12'd1;
                    if (r_tmo_cnt == c_TMO_LAST) begin
                        w_release       = 1'b1;
                        w_tmo_pulse_nxt = 1'b1;
                    end
                end
                // valid high with tx_ready low: owner is stalled by the UART,
                // not idle, so the timeout counter holds.

                if (w_release) begin
                    w_state_nxt       = ARB_IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = w_rr_after;
                    w_burst_cnt_nxt   = '0;
                    w_tmo_cnt_nxt     = '0;
                end
            end

            default: begin
                w_state_nxt       = ARB_IDLE;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.tmo_pulse   = r_tmo_pulse;

endmodule
`default_nettype wire
